// File: rtl/gf_div.sv
// gf_div: sequential GF(2^WIDTH) divider, out = in_1 * in_2^(2^WIDTH - 2).
// The inverse uses Fermat exponentiation by repeated squaring and
// multiplication. One operation runs at a time, with a start/done handshake.
// Optional feature: define GF_DIV_ZERO_CHK_EN to detect a zero divisor.
// With it, a zero divisor skips the exponentiation and raises o_div_zero
// together with o_done.
module gf_div #(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  POLY  = 8'h1B
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic [WIDTH-1:0] out,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_div_zero
);

  localparam int unsigned      CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 2);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, INV, MUL} state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] sq;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] sq2;
  logic [WIDTH-1:0] mul_x;
  logic [WIDTH-1:0] mul_p;

  // Bit-parallel shift-and-add product reduced modulo the field polynomial
  function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] t;
    p = '0;
    t = x;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (y[i]) p = p ^ t;
      t = t[WIDTH-1] ? ((t << 1) ^ POLY) : (t << 1);
    end
    return p;
  endfunction

  // Squarer and the shared multiplier.
  // INV multiplies acc by sq^2; MUL multiplies the dividend by acc.
  always_comb begin
    sq2   = gf_mul(sq, sq);
    mul_x = (state == MUL) ? a : sq2;
    mul_p = gf_mul(mul_x, acc);
  end

`ifdef GF_DIV_ZERO_CHK_EN
  logic zero;
  logic div_zero;

  assign o_div_zero = div_zero;

  // Control FSM with the datapath registers; zero divisors bypass INV
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      a        <= '0;
      sq       <= '0;
      acc      <= '0;
      cnt      <= '0;
      zero     <= 1'b0;
      out      <= '0;
      o_done   <= 1'b0;
      o_busy   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      o_done   <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            a      <= in_1;
            sq     <= in_2;
            acc    <= ONE;
            cnt    <= '0;
            o_busy <= 1'b1;
            zero   <= (in_2 == '0);
            state  <= (in_2 == '0) ? MUL : INV;
          end
        end
        INV: begin
          sq  <= sq2;
          acc <= mul_p;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) state <= MUL;
        end
        MUL: begin
          // acc is still 1 on the bypass path, so force the zero quotient
          out      <= zero ? '0 : mul_p;
          div_zero <= zero;
          o_done   <= 1'b1;
          o_busy   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign o_div_zero = 1'b0;

  // Control FSM with the datapath registers; every operation takes WIDTH cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      a      <= '0;
      sq     <= '0;
      acc    <= '0;
      cnt    <= '0;
      out    <= '0;
      o_done <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            a      <= in_1;
            sq     <= in_2;
            acc    <= ONE;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= INV;
          end
        end
        INV: begin
          sq  <= sq2;
          acc <= mul_p;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) state <= MUL;
        end
        MUL: begin
          out    <= mul_p;
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_gf_div.sv
// tb_gf_div: scoreboard bench for gf_div (WIDTH=8, AES polynomial).
// Stimulus pushes expected results and completion cycles.
// A negedge monitor pops and compares them on every o_done.
module tb_gf_div;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic [7:0] in_1;
  logic [7:0] in_2;
  logic [7:0] out;
  logic       o_done;
  logic       o_busy;
  logic       o_div_zero;

  int unsigned cyc;
  int unsigned checks;
  int unsigned failures;

  typedef struct {
    logic [7:0]  q;
    logic        dz;
    int unsigned done_cyc;
  } exp_t;

  exp_t exp_q[$];

`ifdef GF_DIV_ZERO_CHK_EN
  localparam int unsigned ZERO_LAT = 1;
  localparam logic        ZERO_DZ  = 1'b1;
`else
  localparam int unsigned ZERO_LAT = 8;
  localparam logic        ZERO_DZ  = 1'b0;
`endif

  gf_div #(.WIDTH(8), .POLY(8'h1B)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (i_start),
    .in_1       (in_1),
    .in_2       (in_2),
    .out        (out),
    .o_done     (o_done),
    .o_busy     (o_busy),
    .o_div_zero (o_div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference multiplier: the multiplier operand is consumed from its low bit, with xtime on a
  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = x; bb = y;
    while (bb != 8'h00) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Monitor: every completion must match the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (o_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("quotient", {24'd0, out}, {24'd0, e.q});
          chk("div_zero_at_done", {31'd0, o_div_zero}, {31'd0, e.dz});
          chk("done_cycle", cyc, e.done_cyc);
          chk("busy_at_done", {31'd0, o_busy}, 32'd0);
        end
      end else if (o_div_zero !== 1'b0) begin
        chk("div_zero_idle", {31'd0, o_div_zero}, 32'd0);
      end
    end
  end

  // Called at a negedge: drive operands and start, and record the expected completion
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                       input logic dz, input int unsigned lat);
    in_1    = a;
    in_2    = b;
    i_start = 1'b1;
    exp_q.push_back('{q: q, dz: dz, done_cyc: cyc + 1 + lat});
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    int unsigned nb;
    logic [7:0]  inv;
    cyc = 0; checks = 0; failures = 0;
    rst_n = 1'b0; i_start = 1'b0; in_1 = 8'h00; in_2 = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_out", {24'd0, out}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_div_zero", {31'd0, o_div_zero}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic inverse with a busy-width measurement
    issue(8'h01, 8'h53, 8'hCA, 1'b0, 8);
    @(negedge clk);
    i_start = 1'b0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_done) break;
      if (o_busy) nb++;
      @(negedge clk);
    end
    chk("busy_cycles", nb, 32'd8);
    wait_drain();
    repeat (2) @(negedge clk);

    // Back-to-back operations with start held high
    issue(8'h02, 8'hCA, 8'hA6, 1'b0, 8);
    repeat (9) @(negedge clk);
    issue(8'h53, 8'h53, 8'h01, 1'b0, 8);
    repeat (9) @(negedge clk);
    issue(8'hE9, 8'h01, 8'hE9, 1'b0, 8);
    @(negedge clk);
    i_start = 1'b0;
    wait_drain();
    repeat (2) @(negedge clk);

    // Zero divisor
    issue(8'hE9, 8'h00, 8'h00, ZERO_DZ, ZERO_LAT);
    @(negedge clk);
    i_start = 1'b0;
    wait_drain();
    repeat (2) @(negedge clk);

    // A start pulse and operand change while busy are ignored
    issue(8'h01, 8'h53, 8'hCA, 1'b0, 8);
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    i_start = 1'b1; in_1 = 8'hFF; in_2 = 8'h07;
    @(negedge clk);
    i_start = 1'b0; in_1 = 8'h00; in_2 = 8'h00;
    wait_drain();
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of an operation
    issue(8'h01, 8'h53, 8'hCA, 1'b0, 8);
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("async_rst_out", {24'd0, out}, 32'd0);
    chk("async_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("async_rst_done", {31'd0, o_done}, 32'd0);
    chk("async_rst_div_zero", {31'd0, o_div_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    issue(8'h01, 8'h53, 8'hCA, 1'b0, 8);
    @(negedge clk);
    i_start = 1'b0;
    wait_drain();
    repeat (2) @(negedge clk);

    // Sweep every nonzero divisor with a = 1 against a brute-force inverse
    for (int b = 1; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++) begin
        if (ref_mul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      end
      issue(8'h01, 8'(b), inv, 1'b0, 8);
      @(negedge clk);
      i_start = 1'b0;
      wait_drain();
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
